// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: tagged BTB + gshare PHT + speculative GHR with mispredict repair.
// IF side: i_if_valid/i_if_stall/i_if_pc/i_if_is_cond in; o_pred_taken/o_pred_target/o_if_ghr out (combinational lookup).
// EX side: i_ex_* resolution in; o_flush/o_redirect_pc out (combinational); tables train on the next clock edge.
// Clock i_clk (rising), reset i_rst (asynchronous, active-high).
// Optional macro GSHARE_BP_STATS_EN adds o_stat_lookups/o_stat_cond_resolved/o_stat_mispredicts counters.
module gshare_branch_predictor #(
  parameter int         BTB_ENTRIES = 256,
  parameter int         PHT_ENTRIES = 1024,
  parameter int         GHR_BITS    = 8,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_valid,
  input  logic                i_if_stall,
  input  logic [31:0]         i_if_pc,
  input  logic                i_if_is_cond,
  output logic                o_pred_taken,
  output logic [31:0]         o_pred_target,
  output logic [GHR_BITS-1:0] o_if_ghr,
  input  logic                i_ex_valid,
  input  logic [31:0]         i_ex_pc,
  input  logic                i_ex_is_cond,
  input  logic                i_ex_is_jump,
  input  logic                i_ex_taken,
  input  logic [31:0]         i_ex_target,
  input  logic                i_ex_pred_taken,
  input  logic [31:0]         i_ex_pred_target,
  input  logic [GHR_BITS-1:0] i_ex_ghr,
`ifdef GSHARE_BP_STATS_EN
  output logic [31:0]         o_stat_lookups,
  output logic [31:0]         o_stat_cond_resolved,
  output logic [31:0]         o_stat_mispredicts,
`endif
  output logic                o_flush,
  output logic [31:0]         o_redirect_pc
);
  localparam int BB = $clog2(BTB_ENTRIES);
  localparam int PB = $clog2(PHT_ENTRIES);
  localparam int TW = 30 - BB;
  logic                btb_v_q   [BTB_ENTRIES];
  logic [TW-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [29:0]         btb_tgt_q [BTB_ENTRIES];
  logic                btb_unc_q [BTB_ENTRIES];
  logic [1:0]          pht_q     [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [BB-1:0]       if_bidx, ex_bidx;
  logic [PB-1:0]       if_pidx, ex_pidx;
  logic                hit, unc, dir, spec, train;
  logic [1:0]          ex_ctr, ctr_d;
  logic [31:0]         true_pc;
  logic                unused_ok;
  // The carried direction bit is implied by the carried target, so it is not needed here.
  assign unused_ok     = i_ex_pred_taken;
  assign if_bidx       = i_if_pc[BB+1:2];
  assign if_pidx       = i_if_pc[PB+1:2] ^ PB'(ghr_q);
  assign hit           = btb_v_q[if_bidx] & (btb_tag_q[if_bidx] == i_if_pc[31:BB+2]);
  assign unc           = btb_unc_q[if_bidx];
  assign dir           = pht_q[if_pidx][1];
  assign o_pred_taken  = i_if_valid & hit & (unc | dir);
  assign o_pred_target = o_pred_taken ? {btb_tgt_q[if_bidx], 2'b00} : i_if_pc + 32'd4;
  assign o_if_ghr      = ghr_q;
  assign spec          = i_if_valid & ~i_if_stall & i_if_is_cond & hit & ~unc;
  assign train         = i_ex_valid & (i_ex_is_cond | i_ex_is_jump);
  assign ex_bidx       = i_ex_pc[BB+1:2];
  assign ex_pidx       = i_ex_pc[PB+1:2] ^ PB'(i_ex_ghr);
  assign ex_ctr        = pht_q[ex_pidx];
  assign ctr_d         = i_ex_taken ? (&ex_ctr ? ex_ctr : ex_ctr + 2'd1)
                                    : (|ex_ctr ? ex_ctr - 2'd1 : ex_ctr);
  assign true_pc       = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
  assign o_flush       = train & (true_pc != i_ex_pred_target);
  assign o_redirect_pc = o_flush ? true_pc : 32'd0;
  // Flush repair wins over IF speculation; jumps restore the snapshot without recording a bit.
  always_comb begin
    ghr_d = o_flush & i_ex_is_cond ? GHR_BITS'({i_ex_ghr, i_ex_taken}) :
            o_flush                ? i_ex_ghr :
            spec                   ? GHR_BITS'({ghr_q, dir}) : ghr_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ghr_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_v_q[i] <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_INIT;
    end else begin
      ghr_q <= ghr_d;
      if (train & i_ex_taken) btb_v_q[ex_bidx] <= 1'b1;
      if (train & i_ex_is_cond) pht_q[ex_pidx] <= ctr_d;
    end
  end
  // Payload fields are qualified by the valid bit, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (train & i_ex_taken) begin
      btb_tag_q[ex_bidx] <= i_ex_pc[31:BB+2];
      btb_tgt_q[ex_bidx] <= i_ex_target[31:2];
      btb_unc_q[ex_bidx] <= i_ex_is_jump;
    end
  end
`ifdef GSHARE_BP_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stat_lookups       <= '0;
      o_stat_cond_resolved <= '0;
      o_stat_mispredicts   <= '0;
    end else begin
      if (i_if_valid & ~i_if_stall) o_stat_lookups <= o_stat_lookups + 32'd1;
      if (train & i_ex_is_cond) o_stat_cond_resolved <= o_stat_cond_resolved + 32'd1;
      if (o_flush) o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed stimulus with queued expectations checked by a monitor.
module tb_gshare_branch_predictor;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid, if_stall, if_is_cond, pred_taken;
  logic [31:0] if_pc, pred_target;
  logic [7:0]  if_ghr;
  logic        ex_valid, ex_is_cond, ex_is_jump, ex_taken, ex_pred_taken, flush;
  logic [31:0] ex_pc, ex_target, ex_pred_target, redirect_pc;
  logic [7:0]  ex_ghr;
`ifdef GSHARE_BP_STATS_EN
  logic [31:0] st_lk, st_cr, st_mp;
`endif
  typedef struct { string n; logic t; logic [31:0] tgt; logic [7:0] g; } if_e;
  typedef struct { string n; logic f; logic [31:0] pc; } ex_e;
  if_e ifq[$];
  ex_e exq[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  gshare_branch_predictor dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_valid(if_valid), .i_if_stall(if_stall), .i_if_pc(if_pc), .i_if_is_cond(if_is_cond),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target), .o_if_ghr(if_ghr),
    .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_ex_is_cond(ex_is_cond), .i_ex_is_jump(ex_is_jump),
    .i_ex_taken(ex_taken), .i_ex_target(ex_target), .i_ex_pred_taken(ex_pred_taken),
    .i_ex_pred_target(ex_pred_target), .i_ex_ghr(ex_ghr),
`ifdef GSHARE_BP_STATS_EN
    .o_stat_lookups(st_lk), .o_stat_cond_resolved(st_cr), .o_stat_mispredicts(st_mp),
`endif
    .o_flush(flush), .o_redirect_pc(redirect_pc)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if_e ie;
    ex_e ee;
    if (!rst && if_valid) begin
      if (ifq.size() == 0) chk("if_queue_underflow", 32'(ifq.size()), 32'd1);
      else begin
        ie = ifq.pop_front();
        chk({ie.n, ".taken"}, 32'(pred_taken), 32'(ie.t));
        chk({ie.n, ".target"}, pred_target, ie.tgt);
        chk({ie.n, ".ghr"}, 32'(if_ghr), 32'(ie.g));
      end
    end
    if (!rst && ex_valid) begin
      if (exq.size() == 0) chk("ex_queue_underflow", 32'(exq.size()), 32'd1);
      else begin
        ee = exq.pop_front();
        chk({ee.n, ".flush"}, 32'(flush), 32'(ee.f));
        chk({ee.n, ".redirect"}, redirect_pc, ee.pc);
      end
    end
  end
  task automatic lk(string n, logic [31:0] pc, logic cond, logic stall, logic t, logic [31:0] tgt, logic [7:0] g);
    if_valid = 1'b1; if_pc = pc; if_is_cond = cond; if_stall = stall;
    ifq.push_back('{n, t, tgt, g});
  endtask
  task automatic ex(string n, logic [31:0] pc, logic cond, logic jump, logic tk, logic [31:0] tgt,
                    logic [31:0] ptgt, logic [7:0] g, logic f, logic [31:0] rpc);
    ex_valid = 1'b1; ex_pc = pc; ex_is_cond = cond; ex_is_jump = jump; ex_taken = tk;
    ex_target = tgt; ex_pred_target = ptgt; ex_pred_taken = (ptgt != pc + 32'd4); ex_ghr = g;
    exq.push_back('{n, f, rpc});
  endtask
  task automatic step();
    @(posedge clk); #1;
    if_valid = 1'b0; if_stall = 1'b0; if_is_cond = 1'b0; if_pc = '0;
    ex_valid = 1'b0; ex_is_cond = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0; ex_pred_taken = 1'b0; ex_ghr = '0;
  endtask
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    step();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lk("reset_lookup", 32'h100, 0, 0, 0, 32'h104, 8'h00); step();
    ex("non_control", 32'h100, 0, 0, 0, 32'h0, 32'h999, 8'h00, 0, 32'h0); step();
    ex("jump_0x100", 32'h100, 0, 1, 1, 32'h500, 32'h104, 8'h00, 1, 32'h500); step();
    lk("jump_0x100_hit", 32'h100, 0, 0, 1, 32'h500, 8'h00); step();
    ex("cold_branch", 32'h200, 1, 0, 1, 32'h400, 32'h204, 8'h00, 1, 32'h400); step();
    ex("ghr_clear_jump", 32'h610, 0, 1, 1, 32'h700, 32'h614, 8'h00, 1, 32'h700); step();
    lk("cold_branch_hit", 32'h200, 1, 0, 1, 32'h400, 8'h00); step();
    lk("spec_shift", 32'h204, 0, 0, 0, 32'h208, 8'h01); step();
    for (int i = 0; i < 4; i++) begin
      ex("sat_not_taken", 32'h200, 1, 0, 0, 32'h400, 32'h204, 8'h01, 0, 32'h0); step();
    end
    ex("sat_taken1", 32'h200, 1, 0, 1, 32'h400, 32'h400, 8'h01, 0, 32'h0); step();
    lk("sat_ctr01", 32'h200, 1, 1, 0, 32'h204, 8'h01); step();
    ex("sat_taken2", 32'h200, 1, 0, 1, 32'h400, 32'h400, 8'h01, 0, 32'h0); step();
    lk("sat_ctr10", 32'h200, 1, 0, 1, 32'h400, 8'h01); step();
    lk("spec_shift2", 32'h204, 0, 0, 0, 32'h208, 8'h03); step();
    ex("jal", 32'h300, 0, 1, 1, 32'h800, 32'h304, 8'h03, 1, 32'h800); step();
    lk("jal_hit", 32'h300, 1, 0, 1, 32'h800, 8'h03); step();
    lk("jal_ghr_held", 32'h204, 0, 0, 0, 32'h208, 8'h03); step();
    lk("race_if", 32'h200, 1, 0, 0, 32'h204, 8'h03);
    ex("race_ex", 32'h240, 1, 0, 1, 32'h280, 32'h244, 8'hA5, 1, 32'h280); step();
    lk("race_ghr", 32'h204, 0, 0, 0, 32'h208, 8'h4B); step();
    lk("no_bypass_if", 32'h2C0, 0, 0, 0, 32'h2C4, 8'h4B);
    ex("no_bypass_ex", 32'h2C0, 0, 1, 1, 32'h900, 32'h2C4, 8'h4B, 1, 32'h900); step();
    lk("no_bypass_after", 32'h2C0, 0, 0, 1, 32'h900, 8'h4B); step();
    pulse_reset();
    lk("midrun_reset_0x100", 32'h100, 0, 0, 0, 32'h104, 8'h00); step();
    lk("midrun_reset_0x300", 32'h300, 0, 0, 0, 32'h304, 8'h00); step();
`ifdef GSHARE_BP_STATS_EN
    pulse_reset();
    chk("stat_lookups_reset", st_lk, 32'd0);
    chk("stat_cond_reset", st_cr, 32'd0);
    chk("stat_misp_reset", st_mp, 32'd0);
    for (int i = 0; i < 10; i++) begin
      lk("stat_lookup", 32'h100, 0, 0, 0, 32'h104, i < 3 ? 8'h00 : 8'h01);
      if (i < 2) ex("stat_nt", 32'h200, 1, 0, 0, 32'h400, 32'h204, 8'h00, 0, 32'h0);
      if (i == 2) ex("stat_flush", 32'h200, 1, 0, 1, 32'h400, 32'h204, 8'h00, 1, 32'h400);
      step();
    end
    lk("stat_stalled", 32'h100, 0, 1, 0, 32'h104, 8'h01); step();
    chk("stat_lookups", st_lk, 32'd10);
    chk("stat_cond", st_cr, 32'd3);
    chk("stat_misp", st_mp, 32'd1);
`endif
    step();
    chk("if_queue_drained", 32'(ifq.size()), 32'd0);
    chk("ex_queue_drained", 32'(exq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
